// File: rtl/llc_mesi_ctrl_pkg.sv
// Shared cache definitions: MESI line states, bus/L1/snoop message codes,
// request opcodes and the controller's FSM states.
package cache_Defs;

   typedef enum logic [1:0] {
      MESI_M = 2'b00,
      MESI_E = 2'b01,
      MESI_S = 2'b10,
      MESI_I = 2'b11
   } mesi_t;

   typedef enum logic [2:0] {
      BUS_NONE       = 3'd0,
      BUS_READ       = 3'd1,
      BUS_WRITE      = 3'd2,
      BUS_INVALIDATE = 3'd3,
      BUS_RWIM       = 3'd4
   } bus_op_t;

   typedef enum logic [1:0] {
      SNP_NOHIT = 2'd0,
      SNP_HIT   = 2'd1,
      SNP_HITM  = 2'd2
   } snoop_res_t;

   typedef enum logic [2:0] {
      L1_NONE           = 3'd0,
      L1_GETLINE        = 3'd1,
      L1_SENDLINE       = 3'd2,
      L1_INVALIDATELINE = 3'd3,
      L1_EVICTLINE      = 3'd4
   } l1_msg_t;

   typedef enum logic [3:0] {
      OP_READ      = 4'd0,
      OP_WRITE     = 4'd1,
      OP_IFETCH    = 4'd2,
      OP_SNP_INV   = 4'd3,
      OP_SNP_READ  = 4'd4,
      OP_SNP_WRITE = 4'd5,
      OP_SNP_RWIM  = 4'd6,
      OP_CLEAR     = 4'd8
   } req_op_t;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOOKUP, ST_WB, ST_EVICT, ST_FILL, ST_DONE, ST_CLEAR
   } state_t;

   function automatic logic is_cpu(input logic [3:0] op);
      return (op == OP_READ) || (op == OP_WRITE) || (op == OP_IFETCH);
   endfunction

   function automatic logic is_snoop(input logic [3:0] op);
      return (op == OP_SNP_INV) || (op == OP_SNP_READ) ||
             (op == OP_SNP_WRITE) || (op == OP_SNP_RWIM);
   endfunction

endpackage

// File: rtl/llc_mesi_ctrl_plru_tree.sv
// Tree pseudo-LRU for one set: next-state bits after touching acc_way, and
// the victim reached by following the current node bits (1 = upper half).
module plru_tree #(
   parameter int WAYS = 8,
   localparam int WW  = $clog2(WAYS)
) (
   input  logic [WAYS-2:0] bits,
   input  logic [WW-1:0]   acc_way,
   output logic [WW-1:0]   victim,
   output logic [WAYS-2:0] bits_nxt
);

   // Heap-ordered nodes: root 0, children of n are 2n+1 (lower) and 2n+2 (upper).
   always_comb begin
      int n;
      bits_nxt = bits;
      victim   = '0;
      n        = 0;
      for (int l = 0; l < WW; l++) begin
         bits_nxt[WW'(n)] = ~acc_way[WW-1-l];
         n = 2*n + 1 + int'(acc_way[WW-1-l]);
      end
      n = 0;
      for (int l = 0; l < WW; l++) begin
         victim[WW-1-l] = bits[WW'(n)];
         n = 2*n + 1 + int'(bits[WW'(n)]);
      end
   end

endmodule

// File: rtl/llc_mesi_ctrl.sv
// Last-level cache MESI controller: tag/state store with tree-PLRU replacement,
// serving one CPU request or bus snoop at a time, plus a full-array clear walk.
module llc_mesi_ctrl
   import cache_Defs::*;
#(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 6,
   parameter int INDEX_W  = 15,
   parameter int WAYS     = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [3:0]              req_op,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [1:0]              bus_snoop_res,
   output logic                    rsp_valid,
   output logic                    rsp_hit,
   output logic [$clog2(WAYS)-1:0] rsp_way,
   output logic [2:0]              bus_op,
   output logic [2:0]              l1_msg,
   output logic [1:0]              snoop_res,
   output logic [31:0]             hit_cnt,
   output logic [31:0]             miss_cnt
);

   localparam int WW    = $clog2(WAYS);
   localparam int SETS  = 2**INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   state_t              state;
   logic [3:0]          op_q;
   logic [INDEX_W-1:0]  idx_q, clr_idx;
   logic [TAG_W-1:0]    tag_r;
   logic [WW-1:0]       way_q, hit_way, inv_way, plru_vic, miss_way, acc_way;
   logic                hit, has_inv;
   mesi_t               hit_st, vic_st, fill_st;
   bus_op_t             fill_bus;
   logic [WAYS-2:0]     plru_nxt;

   logic [TAG_W-1:0]    tags  [SETS][WAYS];
   mesi_t               lines [SETS][WAYS];
   logic [WAYS-2:0]     plru  [SETS];

   logic unused_off;
   assign unused_off = ^req_addr[OFFSET_W-1:0];

   // Descending scan so the lowest-numbered match/invalid way wins.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (lines[idx_q][w] == MESI_I) begin
            has_inv = 1'b1;
            inv_way = WW'(w);
         end else if (tags[idx_q][w] == tag_r) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
      end
   end

   assign hit_st   = lines[idx_q][hit_way];
   assign miss_way = has_inv ? inv_way : plru_vic;
   assign vic_st   = lines[idx_q][miss_way];
   assign acc_way  = (state == ST_FILL) ? way_q : hit_way;
   assign fill_bus = (op_q == OP_WRITE) ? BUS_RWIM : BUS_READ;
   assign fill_st  = (op_q == OP_WRITE) ? MESI_M :
                     ((bus_snoop_res == SNP_HIT) || (bus_snoop_res == SNP_HITM)) ? MESI_S : MESI_E;

   plru_tree #(.WAYS(WAYS)) u_plru (
      .bits     (plru[idx_q]),
      .acc_way  (acc_way),
      .victim   (plru_vic),
      .bits_nxt (plru_nxt)
   );

   always_ff @(posedge clk) begin
      if (state == ST_FILL) tags[idx_q][way_q] <= tag_r;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_hit   <= 1'b0;
         rsp_way   <= '0;
         bus_op    <= BUS_NONE;
         l1_msg    <= L1_NONE;
         snoop_res <= SNP_NOHIT;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
         op_q      <= '0;
         idx_q     <= '0;
         tag_r     <= '0;
         way_q     <= '0;
         clr_idx   <= '0;
         for (int s = 0; s < SETS; s++) begin
            plru[s] <= '0;
            for (int w = 0; w < WAYS; w++) lines[s][w] <= MESI_I;
         end
      end else begin
         // Outputs are registered: each branch sets what the next state shows.
         rsp_valid <= 1'b0;
         bus_op    <= BUS_NONE;
         l1_msg    <= L1_NONE;
         snoop_res <= SNP_NOHIT;
         case (state)
            ST_IDLE: if (req_valid && req_ready) begin
               req_ready <= 1'b0;
               op_q      <= req_op;
               idx_q     <= req_addr[OFFSET_W +: INDEX_W];
               tag_r     <= req_addr[ADDR_W-1 -: TAG_W];
               if (req_op == OP_CLEAR) begin
                  clr_idx <= '0;
                  state   <= ST_CLEAR;
               end else if (is_cpu(req_op) || is_snoop(req_op)) begin
                  state <= ST_LOOKUP;
               end else begin
                  state <= ST_DONE;
               end
            end
            ST_LOOKUP: begin
               if (is_cpu(op_q) && hit) begin
                  if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                  if (op_q == OP_WRITE) begin
                     lines[idx_q][hit_way] <= MESI_M;
                     if (hit_st == MESI_S) bus_op <= BUS_INVALIDATE;
                  end
                  plru[idx_q] <= plru_nxt;
                  rsp_valid   <= 1'b1;
                  rsp_hit     <= 1'b1;
                  rsp_way     <= hit_way;
                  l1_msg      <= L1_SENDLINE;
                  state       <= ST_DONE;
               end else if (is_cpu(op_q)) begin
                  if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                  way_q <= miss_way;
                  if (vic_st == MESI_M) begin
                     bus_op <= BUS_WRITE;
                     l1_msg <= L1_GETLINE;
                     state  <= ST_WB;
                  end else if (vic_st != MESI_I) begin
                     l1_msg <= L1_EVICTLINE;
                     state  <= ST_EVICT;
                  end else begin
                     bus_op    <= fill_bus;
                     l1_msg    <= L1_SENDLINE;
                     rsp_valid <= 1'b1;
                     rsp_hit   <= 1'b0;
                     rsp_way   <= miss_way;
                     state     <= ST_FILL;
                  end
               end else begin
                  state <= ST_DONE;
                  if (hit) begin
                     snoop_res <= (hit_st == MESI_M) ? SNP_HITM : SNP_HIT;
                     case (op_q)
                        OP_SNP_READ: begin
                           lines[idx_q][hit_way] <= MESI_S;
                           if (hit_st == MESI_M) begin
                              bus_op <= BUS_WRITE;
                              l1_msg <= L1_GETLINE;
                           end
                        end
                        OP_SNP_INV, OP_SNP_RWIM: begin
                           lines[idx_q][hit_way] <= MESI_I;
                           l1_msg <= L1_INVALIDATELINE;
                           if (hit_st == MESI_M) bus_op <= BUS_WRITE;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            ST_WB: begin
               l1_msg <= L1_EVICTLINE;
               state  <= ST_EVICT;
            end
            ST_EVICT: begin
               bus_op    <= fill_bus;
               l1_msg    <= L1_SENDLINE;
               rsp_valid <= 1'b1;
               rsp_hit   <= 1'b0;
               rsp_way   <= way_q;
               state     <= ST_FILL;
            end
            ST_FILL: begin
               lines[idx_q][way_q] <= fill_st;
               plru[idx_q]         <= plru_nxt;
               req_ready           <= 1'b1;
               state               <= ST_IDLE;
            end
            ST_DONE: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            ST_CLEAR: begin
               plru[clr_idx] <= '0;
               for (int w = 0; w < WAYS; w++) lines[clr_idx][w] <= MESI_I;
               if (&clr_idx) begin
                  rsp_valid <= 1'b1;
                  rsp_hit   <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  clr_idx <= clr_idx + 1'b1;
               end
            end
            default: begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_llc_mesi_ctrl.sv
// Directed bench for llc_mesi_ctrl: stimulus queues expected output events,
// an independent negedge monitor pops and compares them.
module tb_llc_mesi_ctrl;
   import cache_Defs::*;

   logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0;
   logic        req_ready, rsp_valid, rsp_hit;
   logic [3:0]  req_op = '0;
   logic [31:0] req_addr = '0;
   logic [1:0]  bus_snoop_res = '0, snoop_res;
   logic [2:0]  rsp_way, bus_op, l1_msg;
   logic [31:0] hit_cnt, miss_cnt;

   llc_mesi_ctrl #(.ADDR_W(32), .OFFSET_W(6), .INDEX_W(2), .WAYS(8)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_addr(req_addr), .bus_snoop_res(bus_snoop_res),
      .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .bus_op(bus_op),
      .l1_msg(l1_msg), .snoop_res(snoop_res), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      int         id;
      logic       rv;
      logic       hit;
      logic       cw;
      logic [2:0] way;
      logic [2:0] bop;
      logic [2:0] l1;
      logic [1:0] sr;
   } ev_t;

   ev_t q[$];
   ev_t e;
   int  checks = 0, failures = 0, cyc = 0, acc = 0, nid = 0;
   int  exp_hit = 0, exp_miss = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && (rsp_valid || bus_op != 0 || l1_msg != 0 || snoop_res != 0)) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected cyc=%0d got rv=%0d bus=%0d l1=%0d snp=%0d, want no event",
                     cyc, rsp_valid, bus_op, l1_msg, snoop_res);
         end else begin
            e = q.pop_front();
            if (cyc != e.cyc || rsp_valid != e.rv || bus_op != e.bop || l1_msg != e.l1 ||
                snoop_res != e.sr || (e.rv && rsp_hit != e.hit) || (e.cw && rsp_way != e.way)) begin
               failures++;
               $display("FAIL sb_ev%0d got cyc=%0d rv=%0d hit=%0d way=%0d bus=%0d l1=%0d snp=%0d want cyc=%0d rv=%0d hit=%0d way=%0d bus=%0d l1=%0d snp=%0d",
                        e.id, cyc, rsp_valid, rsp_hit, rsp_way, bus_op, l1_msg, snoop_res,
                        e.cyc, e.rv, e.hit, e.way, e.bop, e.l1, e.sr);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (req_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout got=%0d want=1", req_ready);
      end
      acc = cyc;
   endtask

   task automatic expect_ev(input int k, input logic rv, input logic hit, input logic cw,
                            input logic [2:0] way, input logic [2:0] bop,
                            input logic [2:0] l1, input logic [1:0] sr);
      ev_t x;
      x.cyc = acc + k; x.id = nid; x.rv = rv; x.hit = hit; x.cw = cw;
      x.way = way; x.bop = bop; x.l1 = l1; x.sr = sr;
      nid++;
      q.push_back(x);
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [1:0] sres);
      req_valid = 1'b1; req_op = op; req_addr = a; bus_snoop_res = sres;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic cpu_hit(input logic [3:0] op, input logic [31:0] a, input logic [2:0] way,
                          input logic [2:0] bop);
      wait_idle();
      expect_ev(2, 1'b1, 1'b1, 1'b1, way, bop, L1_SENDLINE, SNP_NOHIT);
      exp_hit++;
      drive(op, a, SNP_NOHIT);
   endtask

   // vict: 0 = invalid way used, 1 = clean valid victim, 2 = modified victim
   task automatic cpu_fill(input logic [3:0] op, input logic [31:0] a, input logic [2:0] way,
                           input logic [1:0] sres, input int vict);
      logic [2:0] fb;
      wait_idle();
      fb = (op == OP_WRITE) ? BUS_RWIM : BUS_READ;
      if (vict == 2) begin
         expect_ev(2, 1'b0, 1'b0, 1'b0, 3'd0, BUS_WRITE, L1_GETLINE, SNP_NOHIT);
         expect_ev(3, 1'b0, 1'b0, 1'b0, 3'd0, BUS_NONE, L1_EVICTLINE, SNP_NOHIT);
      end else if (vict == 1) begin
         expect_ev(2, 1'b0, 1'b0, 1'b0, 3'd0, BUS_NONE, L1_EVICTLINE, SNP_NOHIT);
      end
      expect_ev(2 + vict, 1'b1, 1'b0, 1'b1, way, fb, L1_SENDLINE, SNP_NOHIT);
      exp_miss++;
      drive(op, a, sres);
   endtask

   task automatic snoop(input logic [3:0] op, input logic [31:0] a, input logic [1:0] sr,
                        input logic [2:0] bop, input logic [2:0] l1);
      wait_idle();
      if (sr != 0 || bop != 0 || l1 != 0)
         expect_ev(2, 1'b0, 1'b0, 1'b0, 3'd0, bop, l1, sr);
      drive(op, a, SNP_NOHIT);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_outs", {bus_op, l1_msg, snoop_res}, 0);
      chk("rst_hit_cnt", hit_cnt, 0);
      chk("rst_miss_cnt", miss_cnt, 0);

      // Set 1 (tag 0): fill E, write hit E->M, snoop transitions
      cpu_fill(OP_READ, 32'h40, 3'd0, SNP_NOHIT, 0);
      wait_idle(); chk("miss_after_fill", miss_cnt, 1);
      cpu_hit(OP_WRITE, 32'h40, 3'd0, BUS_NONE);
      wait_idle(); chk("hit_after_write", hit_cnt, 1);
      snoop(OP_SNP_READ, 32'h40, SNP_HITM, BUS_WRITE, L1_GETLINE);
      cpu_hit(OP_READ, 32'h40, 3'd0, BUS_NONE);
      cpu_hit(OP_WRITE, 32'h40, 3'd0, BUS_INVALIDATE);
      snoop(OP_SNP_INV, 32'h40, SNP_HITM, BUS_WRITE, L1_INVALIDATELINE);
      cpu_fill(OP_READ, 32'h40, 3'd0, SNP_HIT, 0);
      snoop(OP_SNP_READ, 32'h40, SNP_HIT, BUS_NONE, L1_NONE);
      snoop(OP_SNP_RWIM, 32'h40, SNP_HIT, BUS_NONE, L1_INVALIDATELINE);
      snoop(OP_SNP_READ, 32'h40, SNP_NOHIT, BUS_NONE, L1_NONE);
      cpu_fill(OP_WRITE, 32'h40, 3'd0, SNP_NOHIT, 0);
      snoop(OP_SNP_WRITE, 32'h40, SNP_HITM, BUS_NONE, L1_NONE);

      // Undefined opcode: done one cycle after acceptance, idle the next
      wait_idle();
      drive(4'd7, 32'h40, SNP_NOHIT);
      chk("noop_busy", req_ready, 0);
      @(negedge clk);
      chk("noop_2cyc", req_ready, 1);
      cpu_hit(OP_IFETCH, 32'h40, 3'd0, BUS_NONE);

      // Fill remaining ways of set 1, then modified way 0 is the victim
      for (int t = 1; t < 8; t++)
         cpu_fill(OP_READ, (t << 8) | 32'h40, 3'(t), SNP_NOHIT, 0);
      cpu_fill(OP_READ, 32'h840, 3'd0, SNP_NOHIT, 2);

      // Set 2: nine distinct tags, ninth evicts clean way 0
      for (int t = 1; t < 10; t++)
         cpu_fill(OP_READ, (t << 8) | 32'h80, 3'((t - 1) % 8), SNP_NOHIT, (t == 9) ? 1 : 0);
      cpu_hit(OP_READ, 32'h280, 3'd1, BUS_NONE);
      cpu_fill(OP_READ, 32'hA80, 3'd4, SNP_NOHIT, 1);
      wait_idle();
      chk("hit_cnt_mid", hit_cnt, exp_hit);
      chk("miss_cnt_mid", miss_cnt, exp_miss);

      // Clear walk: four busy cycles, then idle with a response
      wait_idle();
      expect_ev(5, 1'b1, 1'b0, 1'b0, 3'd0, BUS_NONE, L1_NONE, SNP_NOHIT);
      drive(OP_CLEAR, 32'h0, SNP_NOHIT);
      for (int i = 0; i < 4; i++) begin
         chk("clear_busy", req_ready, 0);
         @(negedge clk);
      end
      chk("clear_done_ready", req_ready, 1);
      chk("clear_hit_held", hit_cnt, exp_hit);
      chk("clear_miss_held", miss_cnt, exp_miss);
      cpu_fill(OP_READ, 32'h280, 3'd0, SNP_NOHIT, 0);
      cpu_fill(OP_WRITE, 32'h840, 3'd0, SNP_NOHIT, 0);

      // Reset in the middle of a clear walk
      wait_idle();
      drive(OP_CLEAR, 32'h0, SNP_NOHIT);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_ready", req_ready, 1);
      chk("midrst_miss", miss_cnt, 0);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("postrst_ready", req_ready, 1);
      exp_miss = 0;
      exp_hit = 0;
      cpu_fill(OP_READ, 32'h280, 3'd0, SNP_NOHIT, 0);
      wait_idle();
      chk("postrst_miss", miss_cnt, exp_miss);

      repeat (3) @(negedge clk);
      chk("sb_pending", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/llc_mesi_ctrl.md
LLC_MESI_CTRL -- requirements
Module: llc_mesi_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter OFFSET_W, default 6, meaning byte-offset bits.
REQ-003 SHALL have parameter INDEX_W, default 15, meaning set-index bits; SETS = 2**INDEX_W.
REQ-004 SHALL have parameter WAYS, default 8, meaning associativity; power of two, at least 2; TAG_W = ADDR_W-INDEX_W-OFFSET_W.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid in 1, req_ready out 1, req_op in 4, req_addr in ADDR_W for the request handshake.
REQ-008 SHALL encode req_op as: 0 read, 1 write, 2 ifetch, 3 snoop-invalidate, 4 snoop-read, 5 snoop-write, 6 snoop-RWIM, 8 clear; other values are no-ops that complete in 2 cycles.
REQ-009 SHALL have port bus_snoop_res  in  2  other caches' result for our own bus READ, sampled in FILL.
REQ-010 SHALL have ports rsp_valid out 1, rsp_hit out 1, rsp_way out $clog2(WAYS), bus_op out 3, l1_msg out 3, snoop_res out 2, hit_cnt out 32, miss_cnt out 32.

Function
REQ-011 SHALL use FSM states IDLE, LOOKUP, WB, EVICT, FILL, DONE, CLEAR; req_ready=1 only in IDLE; a request is accepted when req_valid&&req_ready.
REQ-012 SHALL compare tags of all ways in LOOKUP, one cycle after acceptance; hit = tag match and MESI != I.
REQ-013 SHALL complete a CPU hit in DONE (acceptance+2): rsp_valid=1, rsp_hit=1, l1_msg=SENDLINE, PLRU updated.
REQ-014 SHALL, on a write hit to S, drive bus_op=INVALIDATE in DONE and set M; E->M SHALL be silent.
REQ-015 SHALL, on a CPU miss, choose the lowest-numbered invalid way, else the PLRU victim.
REQ-016 SHALL pass through WB (bus_op=WRITE, l1_msg=GETLINE) only for an M victim, and EVICT (l1_msg=EVICTLINE) only for a valid victim.
REQ-017 SHALL, in FILL, drive bus_op=READ (read/ifetch) or RWIM (write), l1_msg=SENDLINE, rsp_valid=1, rsp_hit=0, and write tag, PLRU and MESI (write->M; read: bus_snoop_res HIT/HITM->S, NOHIT->E).
REQ-018 SHALL process snoops in DONE without PLRU change: snoop_res = HITM for M, HIT for E/S, NOHIT for I/miss.
REQ-019 SHALL apply snoop transitions: snoop-read M->S (bus WRITE, l1 GETLINE), E->S; snoop-RWIM and snoop-invalidate ->I (l1 INVALIDATELINE; M additionally bus WRITE); snoop-write has no effect.
REQ-020 SHALL use a WAYS-1 bit tree PLRU; an access sets each path node to point away from the accessed way; the victim follows the node bits (1 = upper half).
REQ-021 SHALL increment hit_cnt/miss_cnt on CPU ops only, saturating at 2**32-1.
REQ-022 SHALL, on clear, walk sets 0..SETS-1, one per cycle in CLEAR, setting all ways I and PLRU 0, then return to IDLE with rsp_valid=1; counters SHALL be held.
REQ-023 SHALL hold bus_op, l1_msg and snoop_res at 0 and rsp_valid at 0 in every cycle where the rules above do not drive them.

Reset
REQ-024 SHALL, on rst_n low, asynchronously set state IDLE, all lines I, PLRU 0, counters 0 and all outputs 0 except req_ready.
REQ-025 SHALL abort any in-progress operation or clear walk when reset asserts mid-operation, with no partial response after release.

Structure
REQ-026 SHALL take MESI encoding (M=00, E=01, S=10, I=11), bus-op, snoop-result and L1-message codes, and the req_op enum from the shared cache_Defs package.
REQ-027 SHALL place PLRU update and victim selection in the sub-module plru_tree, parameterised by WAYS and purely combinational.

Verification
REQ-028 SHALL check this scenario (INDEX_W=2, WAYS=8): read 0x0000_0040 after reset -> FILL at cycle+2 with bus READ, SENDLINE, way 0; bus_snoop_res=NOHIT gives E; miss_cnt=1.
REQ-029 SHALL check this scenario: write to the same address -> hit at cycle+2, no bus op, state M, hit_cnt=1.
REQ-030 SHALL check this scenario: 9 reads, distinct tags, same set -> 9th evicts way 0 (the PLRU victim), EVICTLINE then READ; an M victim adds a WB cycle with bus WRITE and GETLINE.
REQ-031 SHALL check this scenario: snoop-read to the M line -> snoop_res=HITM, bus WRITE, GETLINE, state S; then snoop-RWIM -> HIT, INVALIDATELINE, state I.
REQ-032 SHALL check this scenario: clear with INDEX_W=2 -> req_ready low for 4 cycles, all lines I; reset asserted mid-clear -> IDLE, no rsp_valid.
